// File: rtl/fb_scan_reader_if.sv
// ----------------------------------------------------------------------------
// fb_scan_reader_if
// Bundles the pixel-stream side and the shared SRAM bus side of the frame
// buffer scan reader.
//   master : the reader (drives pixel outputs, SRAM address/OE, write grant)
//   slave  : the environment (consumer, SRAM, frame-buffer writer)
// Signals:
//   iFrame_Start        restart scan at (0,0), flush FIFO
//   iPix_Req            consumer pops one pixel
//   oPix_Valid          FIFO non-empty
//   oRed/oGreen/oBlue   10-bit colour of FIFO head (zero when empty)
//   oUnderflow          sticky pop-while-empty flag
//   oSRAM_ADDR          read address {x[9:0], y[9:0]}
//   oSRAM_OE_N          SRAM output enable, active-low
//   iSRAM_DQ            SRAM read data
//   iWr_Req / oWr_Gnt   writer bus request / grant
// ----------------------------------------------------------------------------
interface fb_scan_reader_if;
    logic        iFrame_Start;
    logic        iPix_Req;
    logic        oPix_Valid;
    logic [9:0]  oRed;
    logic [9:0]  oGreen;
    logic [9:0]  oBlue;
    logic        oUnderflow;
    logic [19:0] oSRAM_ADDR;
    logic        oSRAM_OE_N;
    logic [15:0] iSRAM_DQ;
    logic        iWr_Req;
    logic        oWr_Gnt;

    modport master (
        input  iFrame_Start, iPix_Req, iSRAM_DQ, iWr_Req,
        output oPix_Valid, oRed, oGreen, oBlue, oUnderflow,
        output oSRAM_ADDR, oSRAM_OE_N, oWr_Gnt
    );

    modport slave (
        output iFrame_Start, iPix_Req, iSRAM_DQ, iWr_Req,
        input  oPix_Valid, oRed, oGreen, oBlue, oUnderflow,
        input  oSRAM_ADDR, oSRAM_OE_N, oWr_Gnt
    );
endinterface

// File: rtl/fb_scan_reader.sv
// ----------------------------------------------------------------------------
// fb_scan_reader
// Walks a frame buffer in raster order, reading one pixel per two clocks from
// an SRAM into a small pixel FIFO, and yields the SRAM bus to a frame-buffer
// writer when the FIFO has enough slack or the scan is finished.
// Ports:
//   iCLK    single clock, rising edge
//   iRST    synchronous active-high reset
//   io_bus  fb_scan_reader_if.master (pixel stream + SRAM bus + writer grant)
// ----------------------------------------------------------------------------
module fb_scan_reader #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    fb_scan_reader_if.master  io_bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] Half  = CntW'(FIFO_DEPTH / 2);
    localparam logic [9:0]      XLast = 10'(H_ACTIVE - 1);
    localparam logic [9:0]      YLast = 10'(V_ACTIVE - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StCapture, StGrant, StDone} state_e;

    state_e             r_state, w_state_d;
    logic [9:0]         r_x, r_y;
    logic               r_done;
    logic [11:0]        r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]    r_wptr, r_rptr;
    logic [CntW-1:0]    r_count;
    logic               r_underflow;

    logic               w_frame, w_push, w_pop, w_empty;
    logic               w_x_last, w_y_last;
    logic [CntW-1:0]    w_count_nxt;
    logic [11:0]        w_head;
    logic               w_unused_dq;

    assign w_frame     = io_bus.iFrame_Start;
    // Frame start discards the word being captured this cycle.
    assign w_push      = (r_state == StCapture) && !w_frame;
    assign w_empty     = (r_count == '0);
    assign w_pop       = io_bus.iPix_Req && !w_empty && !w_frame;
    assign w_count_nxt = r_count + CntW'(w_push) - CntW'(w_pop);
    assign w_x_last    = (r_x == XLast);
    assign w_y_last    = (r_y == YLast);
    assign w_head      = r_mem[r_rptr];
    // Low nibble of the SRAM word carries no colour information.
    assign w_unused_dq = ^io_bus.iSRAM_DQ[3:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_frame) begin
                    w_state_d = StIdle;
                end else if (io_bus.iWr_Req && (r_count >= Half || r_done)) begin
                    w_state_d = StGrant;
                end else if (!r_done && r_count < Depth) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                w_state_d = w_frame ? StIdle : StCapture;
            end
            StCapture: begin
                // Chain straight into the next read when nothing else is
                // pending, giving one pixel every two clocks.
                if (w_frame) begin
                    w_state_d = StIdle;
                end else if (w_x_last && w_y_last) begin
                    w_state_d = StDone;
                end else if (!io_bus.iWr_Req && w_count_nxt < Depth) begin
                    w_state_d = StIssue;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StGrant: begin
                if (!io_bus.iWr_Req) begin
                    w_state_d = (r_done && !w_frame) ? StDone : StIdle;
                end
            end
            StDone: begin
                if (w_frame) begin
                    w_state_d = StIdle;
                end else if (io_bus.iWr_Req) begin
                    w_state_d = StGrant;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        io_bus.oSRAM_ADDR = '0;
        io_bus.oSRAM_OE_N = 1'b1;
        io_bus.oWr_Gnt    = 1'b0;
        unique case (r_state)
            StIssue, StCapture: begin
                io_bus.oSRAM_ADDR = {r_x, r_y};
                io_bus.oSRAM_OE_N = 1'b0;
            end
            StGrant: io_bus.oWr_Gnt = 1'b1;
            default: ;
        endcase
        io_bus.oPix_Valid = !w_empty;
        io_bus.oRed       = w_empty ? 10'd0 : {w_head[11:8], 6'b0};
        io_bus.oGreen     = w_empty ? 10'd0 : {w_head[7:4], 6'b0};
        io_bus.oBlue      = w_empty ? 10'd0 : {w_head[3:0], 6'b0};
        io_bus.oUnderflow = r_underflow;
    end

    // ---------------- Scan pointer and FIFO control ----------------
    always_ff @(posedge iCLK) begin
        if (iRST || w_frame) begin
            r_x         <= '0;
            r_y         <= '0;
            r_done      <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
                if (w_x_last) begin
                    r_x <= '0;
                    if (w_y_last) begin
                        r_y    <= '0;
                        r_done <= 1'b1;
                    end else begin
                        r_y <= r_y + 10'd1;
                    end
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            r_count <= w_count_nxt;
            if (io_bus.iPix_Req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // FIFO storage keeps only the colour bits.
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= io_bus.iSRAM_DQ[15:4];
        end
    end

endmodule
